// File: rtl/sixty_pkg.sv
// sixty_pkg: shared definitions for the sixty timer counters.
// Holds the run-state encoding, BCD digit widths and per-digit maxima used
// by both the up-counter chain and the sixty_down down-counter.
package sixty_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int TENS_W = 3;
  localparam int ONES_W = 4;

  localparam logic [TENS_W-1:0] TENS_MAX = 3'd5;
  localparam logic [ONES_W-1:0] ONES_MAX = 4'd9;

endpackage

// File: rtl/sixty_down_if.sv
// sixty_down_if: control/preset/status bundle of the sixty_down counter.
//   master: drives load, load_tens, load_ones, start, pause, tick;
//           observes tens, ones, borrow, done, busy.
//   slave : the counter side (opposite directions).
interface sixty_down_if;
  import sixty_pkg::*;

  logic              load;
  logic [TENS_W-1:0] load_tens;
  logic [ONES_W-1:0] load_ones;
  logic              start;
  logic              pause;
  logic              tick;
  logic [TENS_W-1:0] tens;
  logic [ONES_W-1:0] ones;
  logic              borrow;
  logic              done;
  logic              busy;

  modport master (
    output load, load_tens, load_ones, start, pause, tick,
    input  tens, ones, borrow, done, busy
  );

  modport slave (
    input  load, load_tens, load_ones, start, pause, tick,
    output tens, ones, borrow, done, busy
  );

endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit that loads a (saturated) preset and counts
// down, wrapping 0 -> MAX.
//   clk, rst   : clock, synchronous active-high reset (digit -> 0)
//   i_ld       : load i_ld_val, clamped to MAX (wins over i_en)
//   i_en       : decrement this cycle
//   o_digit    : registered digit
//   o_zero     : combinational (o_digit == 0), used to borrow from the next digit
module bcd_down_digit #(
  parameter int             W   = 4,
  parameter logic [W-1:0]   MAX = W'(9)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  output logic [W-1:0] o_digit,
  output logic         o_zero
);

  logic [W-1:0] r_digit;

  always_ff @(posedge clk) begin
    if (rst)       r_digit <= '0;
    else if (i_ld) r_digit <= (i_ld_val > MAX) ? MAX : i_ld_val;
    else if (i_en) r_digit <= (r_digit == '0) ? MAX : r_digit - 1'b1;
  end

  assign o_digit = r_digit;
  assign o_zero  = (r_digit == '0);

endmodule

// File: rtl/sixty_down.sv
// sixty_down: two-digit BCD down-counter (59..00) with preset load,
// start/pause control and borrow/expiry reporting.
//   WRAP    : 1 = reload 59 after 00 and keep running; 0 = stop in DONE
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : sixty_down_if.slave (load/preset/start/pause/tick in,
//             tens/ones/borrow/done/busy out, all outputs registered)
module sixty_down
  import sixty_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  sixty_down_if.slave  bus
);

  state_t r_state, w_state_nxt;
  logic   r_borrow, r_done, r_busy;
  logic   w_borrow_nxt;
  logic   w_ones_zero, w_tens_zero, w_all_zero;
  logic   w_run_tick, w_dec;

  assign w_all_zero = w_ones_zero & w_tens_zero;

  // A tick counts only in RUN and only when neither load nor pause claims
  // the cycle; start in RUN is a no-op so it does not block the tick.
  assign w_run_tick = (r_state == ST_RUN) & bus.tick & ~bus.load & ~bus.pause;

  // At 00 the digits wrap to 59 by themselves; without WRAP they must hold.
  assign w_dec = w_run_tick & (WRAP | ~w_all_zero);

  bcd_down_digit #(.W(ONES_W), .MAX(ONES_MAX)) u_ones (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_dec),
    .i_ld     (bus.load),
    .i_ld_val (bus.load_ones),
    .o_digit  (bus.ones),
    .o_zero   (w_ones_zero)
  );

  bcd_down_digit #(.W(TENS_W), .MAX(TENS_MAX)) u_tens (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_dec & w_ones_zero),
    .i_ld     (bus.load),
    .i_ld_val (bus.load_tens),
    .o_digit  (bus.tens),
    .o_zero   (w_tens_zero)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_borrow_nxt = 1'b0;
    if (bus.load) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.pause && r_state == ST_RUN) begin
      w_state_nxt = ST_PAUSED;
    end else if (bus.start && (r_state == ST_IDLE || r_state == ST_PAUSED)) begin
      w_state_nxt = ST_RUN;
    end else if (w_run_tick && w_all_zero) begin
      w_borrow_nxt = 1'b1;
      if (!WRAP) w_state_nxt = ST_DONE;
    end
  end

  // done/busy are flopped from the next state so they move with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_borrow <= w_borrow_nxt;
      r_done   <= (w_state_nxt == ST_DONE);
      r_busy   <= (w_state_nxt == ST_RUN);
    end
  end

  assign bus.borrow = r_borrow;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_sixty_down.sv
// tb_sixty_down: drives a WRAP=0 and a WRAP=1 sixty_down with identical
// stimulus and compares both against an integer-valued timer model.
module tb_sixty_down;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst;
  logic d_load, d_start, d_pause, d_tick;
  logic [2:0] d_lt;
  logic [3:0] d_lo;

  always #5 clk = ~clk;

  sixty_down_if if0 ();
  sixty_down_if if1 ();

  assign if0.load = d_load;  assign if1.load = d_load;
  assign if0.load_tens = d_lt; assign if1.load_tens = d_lt;
  assign if0.load_ones = d_lo; assign if1.load_ones = d_lo;
  assign if0.start = d_start; assign if1.start = d_start;
  assign if0.pause = d_pause; assign if1.pause = d_pause;
  assign if0.tick = d_tick;  assign if1.tick = d_tick;

  sixty_down #(.WRAP(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  sixty_down #(.WRAP(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  // {tens, ones, borrow, done, busy}
  logic [9:0] obs [2];
  assign obs[0] = {if0.tens, if0.ones, if0.borrow, if0.done, if0.busy};
  assign obs[1] = {if1.tens, if1.ones, if1.borrow, if1.done, if1.busy};

  // Model: value as a plain integer 0..59 plus a run state.
  int m_val [2];
  int m_st  [2];
  bit m_brw [2];
  int total = 0;
  int bad   = 0;

  function automatic logic [9:0] expv(input int k);
    logic [2:0] t;
    logic [3:0] o;
    t = 3'(m_val[k] / 10);
    o = 4'(m_val[k] % 10);
    return {t, o, m_brw[k], (m_st[k] == M_DONE), (m_st[k] == M_RUN)};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Apply one cycle of inputs, advance the model, sample at the falling edge.
  task automatic cyc(input bit r, input bit ld, input int lt, input int lo,
                     input bit st, input bit pa, input bit tk);
    rst = r; d_load = ld; d_lt = 3'(lt); d_lo = 4'(lo);
    d_start = st; d_pause = pa; d_tick = tk;
    for (int k = 0; k < 2; k++) begin
      m_brw[k] = 1'b0;
      if (r) begin
        m_val[k] = 0; m_st[k] = M_IDLE;
      end else if (ld) begin
        m_val[k] = imin(lt, 5) * 10 + imin(lo, 9); m_st[k] = M_IDLE;
      end else if (pa && m_st[k] == M_RUN) begin
        m_st[k] = M_PAUSED;
      end else if (st && (m_st[k] == M_IDLE || m_st[k] == M_PAUSED)) begin
        m_st[k] = M_RUN;
      end else if (tk && m_st[k] == M_RUN) begin
        if (m_val[k] == 0) begin
          m_brw[k] = 1'b1;
          if (k == 1) m_val[k] = 59;
          else        m_st[k]  = M_DONE;
        end else begin
          m_val[k] = m_val[k] - 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 0; d_load = 0; d_start = 0; d_pause = 0; d_tick = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs[0] !== 10'd0 || obs[1] !== 10'd0) begin
      bad++; $display("FAIL reset got0=%h got1=%h exp=000", obs[0], obs[1]);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== expv(k) || obs[k][2] !== 1'b0) begin
          bad++; $display("FAIL idle_tick[%0d] got=%h exp=%h", k, obs[k], expv(k));
        end
      end
    end
  endtask

  task automatic test_basic();
    cyc(0, 1, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== expv(k)) begin
          bad++; $display("FAIL basic[%0d] step=%0d got=%h exp=%h", k, i, obs[k], expv(k));
        end
      end
    end
    total++;
    if (obs[0] !== {3'd0, 4'd9, 3'b001}) begin
      bad++; $display("FAIL basic_09 got=%h exp=%h", obs[0], {3'd0, 4'd9, 3'b001});
    end
  endtask

  task automatic test_expiry();
    cyc(0, 1, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (obs[0] !== {3'd0, 4'd0, 3'b001}) begin
      bad++; $display("FAIL expiry_00 got=%h exp=%h", obs[0], {3'd0, 4'd0, 3'b001});
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (obs[0] !== {3'd0, 4'd0, 3'b110}) begin
      bad++; $display("FAIL expiry_done got=%h exp=%h", obs[0], {3'd0, 4'd0, 3'b110});
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (obs[0] !== {3'd0, 4'd0, 3'b010}) begin
      bad++; $display("FAIL expiry_hold got=%h exp=%h", obs[0], {3'd0, 4'd0, 3'b010});
    end
    cyc(0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== expv(k)) begin
        bad++; $display("FAIL expiry_start[%0d] got=%h exp=%h", k, obs[k], expv(k));
      end
    end
  endtask

  task automatic test_wrap();
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (obs[1] !== {3'd5, 4'd9, 3'b101}) begin
      bad++; $display("FAIL wrap_59 got=%h exp=%h", obs[1], {3'd5, 4'd9, 3'b101});
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (obs[1] !== {3'd5, 4'd8, 3'b001}) begin
      bad++; $display("FAIL wrap_58 got=%h exp=%h", obs[1], {3'd5, 4'd8, 3'b001});
    end
  endtask

  task automatic test_collisions();
    cyc(0, 1, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    total++;
    if (obs[0] !== {3'd3, 4'd0, 3'b000}) begin
      bad++; $display("FAIL pause_tick got=%h exp=%h", obs[0], {3'd3, 4'd0, 3'b000});
    end
    cyc(0, 0, 0, 0, 1, 0, 1);
    total++;
    if (obs[0] !== {3'd3, 4'd0, 3'b001}) begin
      bad++; $display("FAIL start_tick got=%h exp=%h", obs[0], {3'd3, 4'd0, 3'b001});
    end
    cyc(0, 1, 4, 5, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== {3'd4, 4'd5, 3'b000}) begin
        bad++; $display("FAIL load_tick[%0d] got=%h exp=%h", k, obs[k], {3'd4, 4'd5, 3'b000});
      end
    end
  endtask

  task automatic test_sat_reset();
    cyc(0, 1, 7, 15, 0, 0, 0);
    total++;
    if (obs[0] !== {3'd5, 4'd9, 3'b000}) begin
      bad++; $display("FAIL saturate got=%h exp=%h", obs[0], {3'd5, 4'd9, 3'b000});
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (obs[0] !== {3'd5, 4'd7, 3'b001}) begin
      bad++; $display("FAIL sat_57 got=%h exp=%h", obs[0], {3'd5, 4'd7, 3'b001});
    end
    cyc(1, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== 10'd0) begin
        bad++; $display("FAIL midrun_rst[%0d] got=%h exp=000", k, obs[k]);
      end
    end
    // start straight from 00: the first tick is the expiry/wrap tick
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== expv(k) || obs[k][2] !== 1'b1) begin
        bad++; $display("FAIL start_at_00[%0d] got=%h exp=%h", k, obs[k], expv(k));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit r, ld, st, pa, tk;
      r  = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 15);
      pa = ($urandom_range(0, 99) < 6);
      tk = ($urandom_range(0, 99) < 70);
      cyc(r, ld, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), st, pa, tk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== expv(k)) begin
          bad++; $display("FAIL random[%0d] cyc=%0d got=%h exp=%h", k, i, obs[k], expv(k));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; d_load = 0; d_lt = 0; d_lo = 0; d_start = 0; d_pause = 0; d_tick = 0;
    for (int k = 0; k < 2; k++) begin m_val[k] = 0; m_st[k] = M_IDLE; m_brw[k] = 0; end
    @(negedge clk);
    test_reset();
    test_basic();
    test_expiry();
    test_wrap();
    test_collisions();
    test_sat_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
